lbp_histogram: RTL and testbench

Downstream consumer of the LBP engine's result bus. Counts the occurrences of each 8-bit LBP code over the 126×126 interior pixels of a 128×128 frame, building a 256-bin histogram. When the engine's `finish` is seen, the block streams the bins out over a valid/ready interface. It is the feature-extraction stage between the LBP engine and any classifier or host readback.

---
 rtl/lbp_pkg.sv | 18 +
 rtl/lbp_hist_bank.sv | 36 +++
 rtl/lbp_histogram.sv | 112 +++++++++++
 tb/tb_lbp_histogram.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP engine and its histogram stage.
package lbp_pkg;
    localparam int IMG_DIM   = 128;
    localparam int ADDR_W    = 14;
    localparam int POS_W     = 7;
    localparam int ROW_MIN   = 1;
    localparam int ROW_MAX   = 126;
    localparam int COL_MIN   = 1;
    localparam int COL_MAX   = 126;
    localparam int HIST_BINS = 256;
    localparam int BIN_W     = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } hist_state_t;
endpackage

// File: rtl/lbp_hist_bank.sv
// 256-entry saturating counter bank: increment lands on the next edge, read port is combinational.
// No backpressure; one increment per cycle, back-to-back hits on the same entry are all counted.
module lbp_hist_bank
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [BIN_W-1:0] idx,
    input  logic [BIN_W-1:0] ridx,
    output logic [CNT_W-1:0] rdata
);
    logic [CNT_W-1:0] cnt_q [HIST_BINS];
    logic [CNT_W-1:0] cnt_d [HIST_BINS];

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q[idx] != '1)) begin
            cnt_d[idx] = cnt_q[idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HIST_BINS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rdata = cnt_q[ridx];
endmodule

// File: rtl/lbp_histogram.sv
// Histograms LBP codes over the frame interior, then streams the 256 bins out after finish.
// Samples count on the next edge; drain is valid/ready, one bin per cycle when ready is held.
module lbp_histogram
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14,
    parameter int DIM   = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic [CNT_W-1:0]  pix_count,
    output logic              addr_err,
    output logic              done
);
    localparam logic [POS_W-1:0] POS_MIN = POS_W'(ROW_MIN);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(DIM - 2);

    hist_state_t      state_q, state_d;
    logic [CNT_W-1:0] pix_count_q, pix_count_d;
    logic             addr_err_q, addr_err_d;
    logic [BIN_W-1:0] hist_bin_q, hist_bin_d;

    logic [POS_W-1:0] row, col;
    logic             interior;
    logic             acc_en;

    assign row      = lbp_addr[ADDR_W-1:POS_W];
    assign col      = lbp_addr[POS_W-1:0];
    assign interior = (row >= POS_MIN) && (row <= POS_MAX) &&
                      (col >= POS_MIN) && (col <= POS_MAX);

    always_comb begin
        state_d     = state_q;
        pix_count_d = pix_count_q;
        addr_err_d  = addr_err_q;
        hist_bin_d  = hist_bin_q;
        acc_en      = 1'b0;
        case (state_q)
            ACCUM: begin
                // A sample arriving with finish is still counted before the drain starts.
                if (lbp_valid) begin
                    if (interior) begin
                        acc_en = 1'b1;
                        if (pix_count_q != '1) begin
                            pix_count_d = pix_count_q + CNT_W'(1);
                        end
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
                if (finish) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // hist_bin parks on 255 so DONE keeps presenting the last bin.
                if (hist_ready) begin
                    if (hist_bin_q == 8'hFF) begin
                        state_d = DONE;
                    end else begin
                        hist_bin_d = hist_bin_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ACCUM;
            pix_count_q <= '0;
            addr_err_q  <= 1'b0;
            hist_bin_q  <= '0;
        end else begin
            state_q     <= state_d;
            pix_count_q <= pix_count_d;
            addr_err_q  <= addr_err_d;
            hist_bin_q  <= hist_bin_d;
        end
    end

    lbp_hist_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk   (clk),
        .reset (reset),
        .en    (acc_en),
        .idx   (lbp_data),
        .ridx  (hist_bin_q),
        .rdata (hist_count)
    );

    assign hist_valid = (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign hist_bin   = hist_bin_q;
    assign pix_count  = pix_count_q;
    assign addr_err   = addr_err_q;
endmodule

// File: tb/tb_lbp_histogram.sv
module tb_lbp_histogram;
    localparam int CNT_W = 14;

    logic             clk;
    logic             reset;
    logic             lbp_valid;
    logic [13:0]      lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic [CNT_W-1:0] pix_count;
    logic             addr_err;
    logic             done;

    lbp_histogram #(.CNT_W(CNT_W), .DIM(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .pix_count  (pix_count),
        .addr_err   (addr_err),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int exp_bins [256];
    int cyc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int r, input int c, input int code, input bit fin);
        lbp_valid = 1'b1;
        lbp_addr  = {7'(r), 7'(c)};
        lbp_data  = 8'(code);
        finish    = finish | fin;
        step();
        lbp_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hvalid"}, 32'(hist_valid), 32'd0);
        chk({tag, "_hbin"},   32'(hist_bin),   32'd0);
        chk({tag, "_hcount"}, 32'(hist_count), 32'd0);
        chk({tag, "_pix"},    32'(pix_count),  32'd0);
        chk({tag, "_aerr"},   32'(addr_err),   32'd0);
        chk({tag, "_done"},   32'(done),       32'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        finish     = 1'b0;
        hist_ready = 1'b0;
        lbp_valid  = 1'b0;
        #2;
        reset = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
        step();
    endtask

    // Accepts bins 0..upto-1, checking each beat against exp_bins.
    task automatic drain(input int upto, input bit rnd, output int cycles);
        int b;
        b = 0;
        cycles = 0;
        while (b < upto) begin
            hist_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hist_ready && hist_valid) begin
                chk("drain_bin", 32'(hist_bin), 32'(b));
                chk("drain_cnt", 32'(hist_count), 32'(exp_bins[b]));
                if (b == 255) chk("done_early", 32'(done), 32'd0);
                b++;
            end
            step();
            cycles++;
            if (cycles > 4000) begin
                chk("drain_timeout", 32'(b), 32'(upto));
                break;
            end
        end
        hist_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
        finish = 1'b0; hist_ready = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;

        // reset values, then idle stays in ACCUM
        #12;
        chk_reset_vals("rst");
        reset = 1'b0;
        step(); step(); step();
        chk_reset_vals("idle");

        // full interior raster, all code 0
        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++)
                send(r, c, 0, 1'b0);
        chk("raster_pix", 32'(pix_count), 32'd15876);
        chk("raster_aerr", 32'(addr_err), 32'd0);
        exp_bins[0] = 15876;
        finish = 1'b1;
        step();
        drain(256, 1'b0, cyc);
        chk("raster_cycles", 32'(cyc), 32'd256);
        chk("raster_done", 32'(done), 32'd1);
        chk("raster_hvalid_off", 32'(hist_valid), 32'd0);
        step(); step();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_bin_hold", 32'(hist_bin), 32'd255);

        // consecutive repeats of 0xA5 plus one 0xFF; samples during DRAIN ignored
        do_reset();
        send(1, 1, 'hA5, 1'b0);
        send(1, 2, 'hA5, 1'b0);
        send(126, 126, 'hA5, 1'b0);
        send(64, 64, 'hFF, 1'b0);
        chk("a5_pix", 32'(pix_count), 32'd4);
        exp_bins['hA5] = 3;
        exp_bins['hFF] = 1;
        finish = 1'b1;
        step();
        send(3, 3, 'hA5, 1'b0);
        send(0, 0, 'hA5, 1'b0);
        chk("drain_ignore_aerr", 32'(addr_err), 32'd0);
        chk("drain_ignore_pix", 32'(pix_count), 32'd4);
        drain(256, 1'b0, cyc);
        chk("a5_done", 32'(done), 32'd1);

        // out-of-interior addresses
        do_reset();
        chk("oob_aerr_pre", 32'(addr_err), 32'd0);
        send(0, 0, 'h33, 1'b0);
        chk("oob_aerr_set", 32'(addr_err), 32'd1);
        send(127, 5, 'h33, 1'b0);
        send(5, 0, 'h33, 1'b0);
        send(5, 127, 'h33, 1'b0);
        chk("oob_pix", 32'(pix_count), 32'd0);
        step();
        chk("oob_aerr_sticky", 32'(addr_err), 32'd1);
        finish = 1'b1;
        step();
        drain(256, 1'b0, cyc);

        // finish coincident with the last valid sample
        do_reset();
        send(10, 10, 'h10, 1'b0);
        send(10, 11, 'h10, 1'b0);
        send(10, 12, 'h10, 1'b1);
        exp_bins['h10] = 3;
        chk("fin_hvalid", 32'(hist_valid), 32'd1);
        chk("fin_hbin", 32'(hist_bin), 32'd0);
        chk("fin_pix", 32'(pix_count), 32'd3);
        drain(256, 1'b0, cyc);

        // backpressure, random ready, then reset mid-drain
        do_reset();
        send(2, 2, 0, 1'b0);
        send(2, 3, 0, 1'b0);
        send(50, 50, 100, 1'b0);
        exp_bins[0] = 2;
        exp_bins[100] = 1;
        finish = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hvalid", 32'(hist_valid), 32'd1);
            chk("bp_hbin", 32'(hist_bin), 32'd0);
            chk("bp_hcount", 32'(hist_count), 32'd2);
            step();
        end
        drain(100, 1'b1, cyc);
        chk("mid_hbin", 32'(hist_bin), 32'd100);
        chk("mid_hcount", 32'(hist_count), 32'd1);
        reset = 1'b1;
        finish = 1'b0;
        #2;
        chk_reset_vals("midrst");
        reset = 1'b0;
        step(); step();
        chk_reset_vals("post_rst");
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
        finish = 1'b1;
        step();
        drain(256, 1'b1, cyc);
        chk("final_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
